// File: rtl/uart_tx_pkg.sv
// Shared UART TX constants and the data-bit clamp used at frame load.
package UART_tx_pkg;

    localparam int UART_DATA_BITS_MIN = 5;
    localparam int UART_DATA_BITS_MAX = 8;
    localparam int UART_TX_FRAME_W    = 10;
    localparam int UART_BAUD_DIV_MIN  = 2;

    function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
        if (bits < 4'(UART_DATA_BITS_MIN)) begin
            return 4'(UART_DATA_BITS_MIN);
        end else if (bits > 4'(UART_DATA_BITS_MAX)) begin
            return 4'(UART_DATA_BITS_MAX);
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with a combinational done compare.
// Shared between the TX and RX datapaths.
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             wait_bit_en,
    input  logic             wait_bit_rst_n,
    output logic             wait_bit_done
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!wait_bit_rst_n) begin
            cnt <= '0;
        end else if (wait_bit_en && (cnt != '1)) begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Done one cycle early: the SHIFT cycle that follows completes the period.
    assign wait_bit_done = wait_bit_en && (cnt == (div - DIV_W'(2)));

endmodule

// File: rtl/uart_tx_shifter.sv
// UART TX datapath: frame builder, shift register, tx line and bit timer.
module uart_tx_shifter
    import UART_tx_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int FRAME_W = UART_TX_FRAME_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tx_data,
    input  logic [3:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             start_bits,
    input  logic             shift_bits,
    input  logic             wait_bit_en,
    input  logic             wait_bit_rst_n,
    output logic             wait_bit_done,
    output logic             tx
);

    logic [DIV_W-1:0]   shadow_div;
    logic [DIV_W-1:0]   div_clamped;
    logic [3:0]         nbits;
    logic [7:0]         data_mask;
    logic               parity_bit;
    logic [FRAME_W-1:0] data_ext;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] sr;

    // Data width and parity are fully consumed when the frame loads, so the
    // loaded shift register is their shadow; only the divisor needs a register.
    always_comb begin
        nbits       = clamp_data_bits(data_bits);
        div_clamped = (baud_div < DIV_W'(UART_BAUD_DIV_MIN)) ?
                      DIV_W'(UART_BAUD_DIV_MIN) : baud_div;
        data_mask   = 8'hFF >> (4'd8 - nbits);
        parity_bit  = (^(tx_data & data_mask)) ^ parity_odd;
        data_ext    = FRAME_W'(tx_data);
        frame       = '1;
        for (int i = 0; i < FRAME_W; i++) begin
            if (i < int'(nbits)) begin
                frame[i] = data_ext[i];
            end else if (i == int'(nbits)) begin
                frame[i] = parity_en ? parity_bit : 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr         <= '1;
            tx         <= 1'b1;
            shadow_div <= DIV_W'(UART_BAUD_DIV_MIN);
        end else if (start_bits) begin
            sr         <= frame;
            tx         <= 1'b0;
            shadow_div <= div_clamped;
        end else if (shift_bits) begin
            tx <= sr[0];
            sr <= {1'b1, sr[FRAME_W-1:1]};
        end
    end

    uart_bit_timer #(
        .DIV_W(DIV_W)
    ) u_bit_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .div           (shadow_div),
        .wait_bit_en   (wait_bit_en),
        .wait_bit_rst_n(wait_bit_rst_n),
        .wait_bit_done (wait_bit_done)
    );

endmodule
